branch_predict_resolve: RTL and testbench
=========================================

Name: branch_predict_resolve

Overview:
- Parametrised successor to the single-cycle branch comparator.
- Resolves conditional branches in EX using signed compares, with two more condition codes than before.
- Keeps a direct-mapped table of 2-bit saturating counters that IF reads for prediction.
- On misprediction, raises a registered flush/redirect; also keeps branch and mispredict statistics counters.

Parameters:
- XLEN, 32, operand width; compares are signed.
- PC_WIDTH, 32, PC and target width.
- BHT_ENTRIES, 64, number of counter entries; must be a power of 2 and at least 2.
- BHT_INIT, 2'b01, counter value after reset (weakly not-taken).
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  synchronous active-low reset
- i_if_pc  in  PC_WIDTH  IF-stage PC used for prediction lookup
- o_pred_taken  out  1  combinational prediction: MSB of the counter at the i_if_pc index
- i_valid  in  1  a resolving instruction is present in EX this cycle
- i_pc  in  PC_WIDTH  PC of the resolving instruction
- i_data1  in  XLEN  rs operand (signed)
- i_data2  in  XLEN  rt operand (signed)
- i_branch  in  3  condition code
- i_pred_taken  in  1  prediction carried down the pipe with this instruction
- i_target  in  PC_WIDTH  branch target address
- o_taken  out  1  combinational actual outcome; 0 when i_valid=0
- o_flush  out  1  registered one-cycle mispredict pulse
- o_redirect_pc  out  PC_WIDTH  registered correct next PC; meaningful only while o_flush=1
- o_branch_cnt  out  CNT_WIDTH  count of resolved branches
- o_miss_cnt  out  CNT_WIDTH  count of mispredicted branches

Behaviour:
- Condition codes (all signed):
  - 000 none
  - 001 beq: d1==d2
  - 010 bne: d1!=d2
  - 011 blez: d1<=0
  - 100 bgtz: d1>0
  - 101 bltz: d1<0
  - 110 bgez: d1>=0
  - 111 reserved: treated as none
- Codes 000 and 111 force o_taken=0, perform no table update and no counting.
- Index: idx = pc[log2(BHT_ENTRIES)+1 : 2]. The same function is used for i_if_pc and i_pc.
- "Resolve" means i_valid=1, code in 001..110, and o_flush=0.
- When o_flush=1, the instruction in EX is wrong-path. It is ignored entirely: no update, no count, no new flush.
- Counter update on resolve, at the clock edge:
  - taken: saturating +1, capped at 2'b11
  - not taken: saturating -1, floored at 2'b00
- Read/write collision: when the IF index equals the EX index in the same cycle, o_pred_taken reflects the pre-update value. There is no bypass.
- Mispredict = resolve AND (o_taken != i_pred_taken). On the next edge:
  - o_flush <= 1
  - o_redirect_pc <= o_taken ? i_target : i_pc + 4, modulo 2^PC_WIDTH
- When there is no mispredict, o_flush <= 0 and o_redirect_pc holds its value.
- o_flush lasts exactly one cycle.
  - A mispredict resolving in the cycle o_flush=1 is impossible by construction, since that instruction is ignored.
- Statistics counters:
  - o_branch_cnt += 1 on every resolve.
  - o_miss_cnt += 1 on every mispredict.
  - Both wrap modulo 2^CNT_WIDTH and never saturate.
- Reset (i_rst_n=0 at an edge):
  - every table entry <= BHT_INIT
  - o_flush, o_redirect_pc, o_branch_cnt, o_miss_cnt <= 0
  - A resolve presented in the same cycle as reset is discarded.
  - Reset mid-flush clears o_flush on that edge.
- Latency:
  - prediction and o_taken: 0 cycles (combinational)
  - flush/redirect and counters: 1 cycle
  - a table update is visible to IF reads 1 cycle later

Decomposition:
- Shared package holds:
  - condition-code constants BR_NONE, BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ
  - 2-bit counter state constants SNT, WNT, WT, ST
- Sub-module branch_cond_eval: purely combinational condition evaluation (d1, d2, code -> taken), parametrised by XLEN.
- Table, flush register and statistics counters live in the top.

Test Plan:
1. Reset, then i_if_pc=0x0000_0040 -> o_pred_taken=0 (entry 16 = 2'b01). All counters 0, o_flush=0.
2. Resolve beq at pc 0x40, d1=d2=5, i_pred_taken=0, target 0x100:
   - Next cycle: o_flush=1, o_redirect_pc=0x100, o_branch_cnt=1, o_miss_cnt=1, entry 16=2'b10.
   - IF read of 0x40 then gives 1.
3. Signed boundaries:
   - bltz d1=0x8000_0000 -> taken.
   - bgez d1=0 -> taken.
   - bgtz d1=0 -> not taken.
   - blez d1=0xFFFF_FFFF -> taken.
   - bne d1=d2=-1 -> not taken.
4. Saturation:
   - Four taken resolves at pc 0x40 -> entry stays 2'b11.
   - Five not-taken resolves -> entry stays 2'b00.
   - A mispredicted not-taken at pc 0xFFFF_FFFC redirects to 0x0000_0000.
5. Wrong-path and collision:
   - Mispredict at cycle N, then a mispredicting resolve at N+1 -> o_flush high only at N+1. Counters and table are unchanged by the N+1 instruction.
   - Same-index IF read during an update returns the old value.
6. Codes 000/111 with i_valid=1 -> o_taken=0, no count change.
   - Reset asserted during the o_flush cycle -> o_flush=0 next edge, table back to 2'b01.
   - With CNT_WIDTH=4, the 16th resolve wraps o_branch_cnt to 0.

Source files
------------

// File: rtl/branch_predict_resolve_pkg.sv
// Shared definitions for the branch resolve / prediction block.
//   Condition codes carried in the EX-stage i_branch field (signed compares).
//   Two-bit saturating predictor counter states.
package branch_predict_resolve_pkg;

  // Branch condition codes
  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLEZ = 3'b011;
  localparam logic [2:0] BR_BGTZ = 3'b100;
  localparam logic [2:0] BR_BLTZ = 3'b101;
  localparam logic [2:0] BR_BGEZ = 3'b110;
  // Reserved encoding, behaves exactly like BR_NONE
  localparam logic [2:0] BR_RSVD = 3'b111;

  // Predictor counter states; MSB set means "predict taken"
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation.
//   d1, d2 : operands, interpreted as two's-complement signed values
//   code   : condition code (BR_* from the package)
//   taken  : 1 when the condition holds; always 0 for BR_NONE / reserved
module branch_cond_eval
  import branch_predict_resolve_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] d1,
  input  logic [XLEN-1:0] d2,
  input  logic [2:0]      code,
  output logic            taken
);

  localparam logic signed [XLEN-1:0] ZERO = '0;

  logic signed [XLEN-1:0] s1;
  logic signed [XLEN-1:0] s2;

  assign s1 = d1;
  assign s2 = d2;

  always_comb begin
    taken = 1'b0;
    case (code)
      BR_BEQ:  taken = (s1 == s2);
      BR_BNE:  taken = (s1 != s2);
      BR_BLEZ: taken = (s1 <= ZERO);
      BR_BGTZ: taken = (s1 >  ZERO);
      BR_BLTZ: taken = (s1 <  ZERO);
      BR_BGEZ: taken = (s1 >= ZERO);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// EX-stage branch resolution with a direct-mapped 2-bit counter predictor.
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_if_pc            : IF-stage PC for the prediction lookup
//   o_pred_taken       : combinational prediction (counter MSB at i_if_pc)
//   i_valid, i_pc      : resolving instruction present in EX and its PC
//   i_data1, i_data2   : signed operands
//   i_branch           : condition code
//   i_pred_taken       : prediction made for this instruction in IF
//   i_target           : taken target
//   o_taken            : combinational actual outcome
//   o_flush            : registered one-cycle mispredict pulse
//   o_redirect_pc      : registered correct next PC, valid with o_flush
//   o_branch_cnt       : resolved-branch count (wrapping)
//   o_miss_cnt         : mispredicted-branch count (wrapping)
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         PC_WIDTH    = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] BHT_INIT    = WNT,
  parameter int         CNT_WIDTH   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [PC_WIDTH-1:0]  i_if_pc,
  output logic                 o_pred_taken,
  input  logic                 i_valid,
  input  logic [PC_WIDTH-1:0]  i_pc,
  input  logic [XLEN-1:0]      i_data1,
  input  logic [XLEN-1:0]      i_data2,
  input  logic [2:0]           i_branch,
  input  logic                 i_pred_taken,
  input  logic [PC_WIDTH-1:0]  i_target,
  output logic                 o_taken,
  output logic                 o_flush,
  output logic [PC_WIDTH-1:0]  o_redirect_pc,
  output logic [CNT_WIDTH-1:0] o_branch_cnt,
  output logic [CNT_WIDTH-1:0] o_miss_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  logic [1:0]          bht [BHT_ENTRIES];
  logic [IDX_W-1:0]    if_idx;
  logic [IDX_W-1:0]    ex_idx;
  logic                cond_taken;
  logic                code_ok;
  logic                resolve;
  logic                mispredict;
  logic                flush_p1;
  logic [PC_WIDTH-1:0] redirect_pc_p1;
  logic [CNT_WIDTH-1:0] branch_cnt_p1;
  logic [CNT_WIDTH-1:0] miss_cnt_p1;
  logic                unused_if_pc;

  // Only the index bits of the IF PC take part in the lookup.
  assign unused_if_pc = ^i_if_pc;

  assign if_idx = i_if_pc[IDX_W+1:2];
  assign ex_idx = i_pc[IDX_W+1:2];

  // Pre-update read: an update in this cycle is seen by IF next cycle.
  assign o_pred_taken = bht[if_idx][1];

  branch_cond_eval #(
    .XLEN (XLEN)
  ) u_cond (
    .d1    (i_data1),
    .d2    (i_data2),
    .code  (i_branch),
    .taken (cond_taken)
  );

  assign o_taken = i_valid & cond_taken;
  assign code_ok = (i_branch != BR_NONE) && (i_branch != BR_RSVD);

  // While a flush is out, the EX instruction is wrong-path and is dropped.
  assign resolve    = i_valid & code_ok & ~flush_p1;
  assign mispredict = resolve & (o_taken != i_pred_taken);

  // ---- stage p1: predictor table update ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= BHT_INIT;
      end
    end else if (resolve) begin
      bht[ex_idx] <= o_taken ? sat_inc(bht[ex_idx]) : sat_dec(bht[ex_idx]);
    end
  end

  // ---- stage p1: flush / redirect and statistics ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      flush_p1       <= 1'b0;
      redirect_pc_p1 <= '0;
      branch_cnt_p1  <= '0;
      miss_cnt_p1    <= '0;
    end else begin
      flush_p1 <= mispredict;
      if (mispredict) begin
        redirect_pc_p1 <= o_taken ? i_target : i_pc + PC_WIDTH'(4);
        miss_cnt_p1    <= miss_cnt_p1 + CNT_WIDTH'(1);
      end
      if (resolve) begin
        branch_cnt_p1 <= branch_cnt_p1 + CNT_WIDTH'(1);
      end
    end
  end

  assign o_flush       = flush_p1;
  assign o_redirect_pc = redirect_pc_p1;
  assign o_branch_cnt  = branch_cnt_p1;
  assign o_miss_cnt    = miss_cnt_p1;

endmodule

// File: tb/tb_branch_predict_resolve.sv
module tb_branch_predict_resolve;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_if_pc;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [31:0] i_data1;
  logic [31:0] i_data2;
  logic [2:0]  i_branch;
  logic        i_pred_taken;
  logic [31:0] i_target;

  logic        o_pred_taken,  o_pred_taken_w4;
  logic        o_taken,       o_taken_w4;
  logic        o_flush,       o_flush_w4;
  logic [31:0] o_redirect_pc, o_redirect_pc_w4;
  logic [31:0] o_branch_cnt,  o_miss_cnt;
  logic [3:0]  o_branch_cnt_w4, o_miss_cnt_w4;

  branch_predict_resolve dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_if_pc       (i_if_pc),
    .o_pred_taken  (o_pred_taken),
    .i_valid       (i_valid),
    .i_pc          (i_pc),
    .i_data1       (i_data1),
    .i_data2       (i_data2),
    .i_branch      (i_branch),
    .i_pred_taken  (i_pred_taken),
    .i_target      (i_target),
    .o_taken       (o_taken),
    .o_flush       (o_flush),
    .o_redirect_pc (o_redirect_pc),
    .o_branch_cnt  (o_branch_cnt),
    .o_miss_cnt    (o_miss_cnt)
  );

  branch_predict_resolve #(.CNT_WIDTH(4)) dut_w4 (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_if_pc       (i_if_pc),
    .o_pred_taken  (o_pred_taken_w4),
    .i_valid       (i_valid),
    .i_pc          (i_pc),
    .i_data1       (i_data1),
    .i_data2       (i_data2),
    .i_branch      (i_branch),
    .i_pred_taken  (i_pred_taken),
    .i_target      (i_target),
    .o_taken       (o_taken_w4),
    .o_flush       (o_flush_w4),
    .o_redirect_pc (o_redirect_pc_w4),
    .o_branch_cnt  (o_branch_cnt_w4),
    .o_miss_cnt    (o_miss_cnt_w4)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model state
  int          m_bht [64];
  bit          m_known;
  bit          m_flush;
  logic [31:0] m_redir;
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;

  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Branch outcome straight from the condition-code table, using int arithmetic.
  function automatic bit m_eval(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (c)
      3'd1: return sa == sb;
      3'd2: return sa != sb;
      3'd3: return sa <= 0;
      3'd4: return sa > 0;
      3'd5: return sa < 0;
      3'd6: return sa >= 0;
      default: return 1'b0;
    endcase
  endfunction

  // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
  task automatic step(input bit rst_n, input bit valid, input logic [31:0] pc,
                      input logic [31:0] d1, input logic [31:0] d2, input logic [2:0] code,
                      input bit pred, input logic [31:0] target, input logic [31:0] if_pc);
    bit t;
    bit resolve;
    bit miss;
    int e_idx;
    int f_idx;
    i_rst_n      = rst_n;
    i_valid      = valid;
    i_pc         = pc;
    i_data1      = d1;
    i_data2      = d2;
    i_branch     = code;
    i_pred_taken = pred;
    i_target     = target;
    i_if_pc      = if_pc;
    #1;
    t     = valid && m_eval(code, d1, d2);
    e_idx = int'((pc >> 2) % 64);
    f_idx = int'((if_pc >> 2) % 64);
    chk("taken", o_taken, t);
    chk("taken_w4", o_taken_w4, t);
    if (m_known) begin
      chk("pred", o_pred_taken, m_bht[f_idx] >= 2);
      chk("pred_w4", o_pred_taken_w4, m_bht[f_idx] >= 2);
    end
    resolve = rst_n && valid && (code >= 3'd1) && (code <= 3'd6) && !m_flush;
    miss    = resolve && (t != pred);
    @(posedge i_clk);
    #1;
    if (!rst_n) begin
      foreach (m_bht[i]) m_bht[i] = 1;
      m_flush = 0;
      m_redir = 0;
      m_bcnt  = 0;
      m_mcnt  = 0;
      m_known = 1;
    end else begin
      if (resolve) begin
        m_bht[e_idx] = t ? ((m_bht[e_idx] < 3) ? m_bht[e_idx] + 1 : 3)
                         : ((m_bht[e_idx] > 0) ? m_bht[e_idx] - 1 : 0);
        m_bcnt = m_bcnt + 1;
      end
      if (miss) begin
        m_mcnt  = m_mcnt + 1;
        m_redir = t ? target : pc + 32'd4;
      end
      m_flush = miss;
    end
    if (m_known) begin
      chk("flush", o_flush, m_flush);
      chk("redir", o_redirect_pc, m_redir);
      chk("bcnt", o_branch_cnt, m_bcnt);
      chk("mcnt", o_miss_cnt, m_mcnt);
      chk("flush_w4", o_flush_w4, m_flush);
      chk("bcnt_w4", o_branch_cnt_w4, m_bcnt % 16);
      chk("mcnt_w4", o_miss_cnt_w4, m_mcnt % 16);
    end
  endtask

  task automatic idle(input logic [31:0] if_pc);
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0, if_pc);
  endtask

  function automatic logic [31:0] pick_d();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'h5;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] pc;
    logic [31:0] d1;
    n_checks = 0;
    n_fail   = 0;
    m_known  = 0;
    m_flush  = 0;
    m_redir  = 0;
    m_bcnt   = 0;
    m_mcnt   = 0;

    // Reset and initial prediction state
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0, 32'h40);
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0, 32'h40);
    idle(32'h40);
    chk("init_pred_0x40", o_pred_taken, 1'b0);

    // beq mispredicted as not-taken
    step(1'b1, 1'b1, 32'h40, 32'd5, 32'd5, 3'd1, 1'b0, 32'h100, 32'h40);
    chk("beq_flush", o_flush, 1'b1);
    chk("beq_redir", o_redirect_pc, 32'h100);
    idle(32'h40);
    chk("beq_pred_after", o_pred_taken, 1'b1);

    // Signed boundaries
    step(1'b1, 1'b1, 32'h200, 32'h8000_0000, 32'h0, 3'd5, 1'b1, 32'h300, 32'h0);
    chk("bltz_min", o_taken, 1'b1);
    step(1'b1, 1'b1, 32'h204, 32'h0, 32'h0, 3'd6, 1'b1, 32'h300, 32'h0);
    step(1'b1, 1'b1, 32'h208, 32'h0, 32'h0, 3'd4, 1'b0, 32'h300, 32'h0);
    step(1'b1, 1'b1, 32'h20C, 32'hFFFF_FFFF, 32'h0, 3'd3, 1'b1, 32'h300, 32'h0);
    step(1'b1, 1'b1, 32'h210, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 1'b0, 32'h300, 32'h0);

    // Saturation up then down at 0x40
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h40, 32'd7, 32'd7, 3'd1, 1'b1, 32'h100, 32'h40);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'h40, 32'd7, 32'd7, 3'd2, 1'b0, 32'h100, 32'h40);
    idle(32'h40);
    // Not-taken mispredict at the top of the address space wraps to 0
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 32'd1, 32'd1, 3'd2, 1'b1, 32'h100, 32'h0);
    chk("wrap_redir", o_redirect_pc, 32'h0);
    idle(32'h0);

    // Back-to-back mispredicts: the second is wrong-path
    step(1'b1, 1'b1, 32'h80, 32'd1, 32'd1, 3'd1, 1'b0, 32'h500, 32'h80);
    step(1'b1, 1'b1, 32'h84, 32'd1, 32'd1, 3'd1, 1'b0, 32'h600, 32'h84);
    chk("wrongpath_flush", o_flush, 1'b0);
    // Same-index read during update returns the old value
    step(1'b1, 1'b1, 32'h84, 32'd3, 32'd3, 3'd1, 1'b1, 32'h600, 32'h84);
    idle(32'h84);

    // Codes none/reserved do nothing
    step(1'b1, 1'b1, 32'h90, 32'd2, 32'd2, 3'd0, 1'b1, 32'h700, 32'h90);
    step(1'b1, 1'b1, 32'h90, 32'd2, 32'd2, 3'd7, 1'b1, 32'h700, 32'h90);

    // Reset during flush cycle
    step(1'b1, 1'b1, 32'h40, 32'd2, 32'd2, 3'd1, 1'b0, 32'h700, 32'h40);
    step(1'b0, 1'b1, 32'h40, 32'd2, 32'd2, 3'd1, 1'b0, 32'h700, 32'h40);
    chk("rst_flush", o_flush, 1'b0);
    idle(32'h40);

    // Sixteen resolves wrap the narrow counter
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 32'hA0, 32'd1, 32'd2, 3'd1, 1'b0, 32'h0, 32'h0);
    chk("w4_wrap", o_branch_cnt_w4, 4'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      pc = ($urandom & 32'hF000_0000) | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 40) == 0) pc = 32'hFFFF_FFFC;
      d1 = pick_d();
      step(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) != 0), pc, d1,
           ($urandom_range(0, 2) == 0) ? d1 : pick_d(), 3'($urandom_range(0, 7)),
           1'($urandom), $urandom,
           ($urandom_range(0, 1) == 0) ? pc : (32'($urandom_range(0, 7)) << 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
